// File: rtl/param_sync_ram.sv
// ----------------------------------------------------------------------------
// param_sync_ram
//
// Parametrised synchronous RAM with one write port and one read port that may
// both be used in the same cycle. After reset a clear sequencer walks every
// word and loads CLEAR_VAL, one word per cycle. init_busy is high while this
// runs, and all accesses are ignored during that time.
//
// Read data is registered, so the read latency is 1 cycle. rd_valid marks
// each completed read.
//
// When the read and write ports hit the same in-range address on the same
// edge, RW_MODE selects what the read returns:
//   0 = read-first  (old contents)
//   1 = write-first (new data)
// The array is updated in both modes.
//
// Optional build macro PARAM_SYNC_RAM_OUT_REG_EN:
//   Adds a second output register stage, giving a 2-cycle read latency.
//   rd_valid travels with the data. Without the macro the output is a
//   single stage.
// ----------------------------------------------------------------------------
module param_sync_ram #(
   parameter int                DATA_W    = 4,
   parameter int                ADDR_W    = 4,
   parameter int                DEPTH     = 16,
   parameter int                RW_MODE   = 0,
   parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic              init_busy
);

   // The clear counter is one bit wider than the address, so that
   // DEPTH == 2**ADDR_W terminates without wrapping.
   localparam int CNT_W = ADDR_W + 1;

   // Index width that exactly covers the storage array.
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(DEPTH - 1);

   localparam logic ST_CLEAR = 1'b0;
   localparam logic ST_READY = 1'b1;

   logic                 state_q;
   logic [CNT_W-1:0]     cnt_q;
   logic [DATA_W-1:0]    mem [0:DEPTH-1];

   logic                 wr_in_range;
   logic                 rd_in_range;
   logic                 collide;
   logic                 mem_we;
   logic [IDX_W-1:0]     mem_wa;
   logic [DATA_W-1:0]    mem_wd;
   logic [DATA_W-1:0]    rd_word;
   logic                 hold_out;

   logic [DATA_W-1:0]    rd_data_s1;
   logic                 rd_valid_s1;

   // Address range checks. Out-of-range accesses never alias or wrap onto
   // real words.
   assign wr_in_range = ({1'b0, wr_addr} < DEPTH_C);
   assign rd_in_range = ({1'b0, rd_addr} < DEPTH_C);
   assign collide     = wr_en && rd_en && rd_in_range && (rd_addr == wr_addr);

   // The output registers are forced to zero during reset and while
   // clearing.
   assign hold_out  = rst || (state_q == ST_CLEAR);
   assign init_busy = (state_q == ST_CLEAR);

   // Sequencer: walk the array after reset, then sit in READY until the
   // next reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_CLEAR;
         cnt_q   <= '0;
      end else if (state_q == ST_CLEAR) begin
         cnt_q <= cnt_q + 1'b1;
         if (cnt_q == LAST_C) begin
            state_q <= ST_READY;
         end
      end
   end

   // Write-port mux: the clear sequencer owns the port in CLEAR, the user
   // owns it in READY. Nothing is written in a reset cycle.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first, so
      // no path leaves a value held, which would infer a latch.
      mem_we = 1'b0;
      mem_wa = wr_addr[IDX_W-1:0];
      mem_wd = wr_data;
      if (!rst) begin
         if (state_q == ST_CLEAR) begin
            mem_we = 1'b1;
            mem_wa = cnt_q[IDX_W-1:0];
            mem_wd = CLEAR_VAL;
         end else if (wr_en && wr_in_range) begin
            mem_we = 1'b1;
         end
      end
   end

   // Storage array write.
   always_ff @(posedge clk) begin
      // NOTE: the array has no reset branch. The clear sequencer gives it
      // known contents, and the array then maps to plain RAM.
      if (mem_we) begin
         mem[mem_wa] <= mem_wd;
      end
   end

   // Read word selection, including the write-first bypass.
   always_comb begin
      rd_word = '0;
      if (rd_in_range) begin
         if ((RW_MODE == 1) && collide) begin
            rd_word = wr_data;
         end else begin
            rd_word = mem[rd_addr[IDX_W-1:0]];
         end
      end
   end

   // First output stage: the registered read result, or zero when idle.
   always_ff @(posedge clk) begin
      // NOTE: the non-blocking array write lands after this read samples
      // mem[], which is what gives read-first behaviour in RW_MODE 0.
      if (hold_out) begin
         rd_data_s1  <= '0;
         rd_valid_s1 <= 1'b0;
      end else begin
         rd_valid_s1 <= rd_en;
         rd_data_s1  <= rd_en ? rd_word : '0;
      end
   end

`ifdef PARAM_SYNC_RAM_OUT_REG_EN
   logic [DATA_W-1:0] rd_data_s2;
   logic              rd_valid_s2;

   // Second output stage: delays both data and valid by one more cycle.
   always_ff @(posedge clk) begin
      if (hold_out) begin
         rd_data_s2  <= '0;
         rd_valid_s2 <= 1'b0;
      end else begin
         rd_data_s2  <= rd_data_s1;
         rd_valid_s2 <= rd_valid_s1;
      end
   end

   assign rd_data  = rd_data_s2;
   assign rd_valid = rd_valid_s2;
`else
   assign rd_data  = rd_data_s1;
   assign rd_valid = rd_valid_s1;
`endif

endmodule
